sys_clint: RTL

- Machine-level interrupt source for the core: 64-bit mtime with prescaler, mtimecmp compare and a software-interrupt bit.
- Presents a request/acknowledge trap interface to the core's system/CSR unit, which redirects fetch to mtvec.
- A small memory-mapped register port lets software program it.
- It is the initiator side of the trap path; the CSR unit is the responder that takes the trap and returns through mret.

---
 rtl/sys_clint_pkg.sv | 28 ++
 rtl/sys_mtimer.sv | 65 ++++++
 rtl/sys_clint.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sys_clint_pkg.sv
// Shared definitions for the machine-level interrupt controller: register
// offsets, mcause codes, trap FSM states and the CTRL register layout.
package sys_clint_pkg;

  localparam logic [2:0] REG_MSIP        = 3'd0;
  localparam logic [2:0] REG_CTRL        = 3'd1;
  localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] REG_MTIME_LO    = 3'd4;
  localparam logic [2:0] REG_MTIME_HI    = 3'd5;
  localparam logic [2:0] REG_STATUS      = 3'd6;

  localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } clint_state_e;

  typedef struct packed {
    logic mtie;
    logic msie;
    logic mie;
  } clint_ctrl_t;

endpackage

// File: rtl/sys_mtimer.sv
// Prescaled 64-bit mtime counter, mtimecmp registers and the mtip compare.
module sys_mtimer
  import sys_clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [2:0]  wr_sel,
  input  logic [31:0] wr_data,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        mtip
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESCALE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] prescale_q, prescale_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          tick;
  logic          wr_time;

  always_comb begin
    tick       = (prescale_q == PRESCALE_MAX);
    prescale_d = tick ? '0 : prescale_q + PW'(1);
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    wr_time    = wr_en && ((wr_sel == REG_MTIME_LO) || (wr_sel == REG_MTIME_HI));

    // A software write to either mtime half suppresses that tick entirely.
    if (tick && !wr_time) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (wr_en) begin
      case (wr_sel)
        REG_MTIMECMP_LO: mtimecmp_d[31:0]  = wr_data;
        REG_MTIMECMP_HI: mtimecmp_d[63:32] = wr_data;
        REG_MTIME_LO:    mtime_d[31:0]     = wr_data;
        REG_MTIME_HI:    mtime_d[63:32]    = wr_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescale_q <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
    end else begin
      prescale_q <= prescale_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
    end
  end

  assign mtime    = mtime_q;
  assign mtimecmp = mtimecmp_q;
  assign mtip     = (mtime_q >= mtimecmp_q);

endmodule

// File: rtl/sys_clint.sv
// Machine-level interrupt source: register port, MSIP/CTRL, and the
// request/acknowledge trap FSM facing the core's CSR unit.
module sys_clint
  import sys_clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reg_vld,
  input  logic            reg_wr,
  input  logic [4:0]      reg_addr,
  input  logic [XLEN-1:0] reg_wdata,
  output logic [XLEN-1:0] reg_rdata,
  output logic            reg_ack,
  output logic            int_req,
  output logic [XLEN-1:0] int_cause,
  input  logic            int_ack,
  input  logic            int_ret
);

  logic            wr_strobe, rd_strobe;
  logic [2:0]      reg_idx;
  logic [63:0]     mtime, mtimecmp;
  logic            mtip;
  logic [31:0]     rd_val, status;
  logic            sw_cand, tm_cand, latched_pending;
  logic            unused_addr;

  logic            msip_q, msip_d;
  clint_ctrl_t     ctrl_q, ctrl_d;
  clint_state_e    state_q, state_d;
  logic            int_req_q, int_req_d;
  logic [XLEN-1:0] int_cause_q, int_cause_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            ack_q, ack_d;

  assign reg_idx     = reg_addr[4:2];
  assign wr_strobe   = reg_vld & reg_wr;
  assign rd_strobe   = reg_vld & ~reg_wr;
  assign unused_addr = ^reg_addr[1:0];

  sys_mtimer #(
    .TICK_DIV (TICK_DIV)
  ) u_mtimer (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_strobe),
    .wr_sel   (reg_idx),
    .wr_data  (reg_wdata[31:0]),
    .mtime    (mtime),
    .mtimecmp (mtimecmp),
    .mtip     (mtip)
  );

  always_comb begin
    msip_d = msip_q;
    ctrl_d = ctrl_q;
    if (wr_strobe && (reg_idx == REG_MSIP)) msip_d = reg_wdata[0];
    if (wr_strobe && (reg_idx == REG_CTRL)) ctrl_d = clint_ctrl_t'(reg_wdata[2:0]);

    status = {26'd0, state_q, 2'b00, mtip, msip_q};
    case (reg_idx)
      REG_MSIP:        rd_val = {31'd0, msip_q};
      REG_CTRL:        rd_val = {29'd0, ctrl_q};
      REG_MTIMECMP_LO: rd_val = mtimecmp[31:0];
      REG_MTIMECMP_HI: rd_val = mtimecmp[63:32];
      REG_MTIME_LO:    rd_val = mtime[31:0];
      REG_MTIME_HI:    rd_val = mtime[63:32];
      REG_STATUS:      rd_val = status;
      default:         rd_val = '0;
    endcase
    rdata_d = rd_strobe ? XLEN'(rd_val) : '0;
    ack_d   = reg_vld;
  end

  always_comb begin
    sw_cand = ctrl_q.mie & ctrl_q.msie & msip_q;
    tm_cand = ctrl_q.mie & ctrl_q.mtie & mtip;
    // The latched cause identifies which source must stay pending in REQ.
    latched_pending = (int_cause_q == XLEN'(CAUSE_MSI)) ? sw_cand : tm_cand;

    state_d     = state_q;
    int_req_d   = int_req_q;
    int_cause_d = int_cause_q;
    case (state_q)
      ST_IDLE: begin
        if (sw_cand) begin
          int_cause_d = XLEN'(CAUSE_MSI);
          int_req_d   = 1'b1;
          state_d     = ST_REQ;
        end else if (tm_cand) begin
          int_cause_d = XLEN'(CAUSE_MTI);
          int_req_d   = 1'b1;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          int_req_d = 1'b0;
          state_d   = ST_SERVICE;
        end else if (!latched_pending) begin
          int_req_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        int_req_d = 1'b0;
        if (int_ret) state_d = ST_IDLE;
      end
      default: begin
        int_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msip_q      <= 1'b0;
      ctrl_q      <= '0;
      state_q     <= ST_IDLE;
      int_req_q   <= 1'b0;
      int_cause_q <= '0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
    end else begin
      msip_q      <= msip_d;
      ctrl_q      <= ctrl_d;
      state_q     <= state_d;
      int_req_q   <= int_req_d;
      int_cause_q <= int_cause_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
    end
  end

  assign reg_rdata = rdata_q;
  assign reg_ack   = ack_q;
  assign int_req   = int_req_q;
  assign int_cause = int_cause_q;

endmodule
